// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM between NUM_REQ requesters (0 = RX loader, 1 = SF, 2 = TX).
// Round-robin grant with optional burst lock. Grant, rvalid, busy and timeout are registered.
// RAM controls are a combinational mux driven from the registered owner.
// Optional feature macro: ARB_TIMEOUT_EN adds a forced release after MAX_HOLD owned cycles.
module ram_port_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          lock,
   input  logic [NUM_REQ-1:0]          we,
   input  logic [NUM_REQ*ADDR_W-1:0]   addr,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic                        ram_cs,
   output logic                        ram_we,
   output logic                        ram_oe,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [DATA_W-1:0]           ram_wdata,
   input  logic [DATA_W-1:0]           ram_rdata,
   output logic                        busy,
   output logic                        timeout
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   state_t             state_r, state_n;
   logic [NUM_REQ-1:0] gnt_r, gnt_n;
   logic [NUM_REQ-1:0] rvalid_r, rvalid_n;
   logic [NUM_REQ-1:0] owner_mask_s, cand_s;
   logic [IDX_W-1:0]   owner_r, owner_n;
   logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_n;
   logic [IDX_W-1:0]   win_idx_s;
   logic [IDX_W:0]     pick_s;
   logic               win_found_s;
   logic               access_s, release_s, force_s, new_grant_s;
   logic               timeout_r;

   // Round-robin search: first candidate at ptr, ptr+1, ... (mod NUM_REQ); MSB = found.
   function automatic logic [IDX_W:0] pick_winner(input logic [NUM_REQ-1:0] cand,
                                                  input logic [IDX_W-1:0]   ptr);
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] pidx;
      int               pos;
      res = {(IDX_W+1){1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end else begin
            pos = pos;
         end
         pidx = pos[IDX_W-1:0];
         if (!res[IDX_W] && cand[pidx]) begin
            res = {1'b1, pidx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign owner_mask_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   logic [HOLD_W-1:0] hold_cnt_r;

   assign force_s = (state_r == OWNED) && (hold_cnt_r == HOLD_W'(MAX_HOLD));

   // Count consecutive owned cycles of the current owner; restart at 1 on every new grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= {HOLD_W{1'b0}};
      end else if (new_grant_s) begin
         hold_cnt_r <= HOLD_W'(1);
      end else if ((state_r == OWNED) && !release_s && (hold_cnt_r != HOLD_W'(MAX_HOLD))) begin
         hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end
`else
   assign force_s = 1'b0;
`endif

   // Classify the current cycle: RAM access by the owner and/or release of the grant.
   always_comb begin
      access_s  = 1'b0;
      release_s = 1'b0;
      if (state_r == OWNED) begin
         access_s  = req[owner_r];
         release_s = ~req[owner_r] | ~lock[owner_r] | force_s;
      end else begin
         access_s  = 1'b0;
         release_s = 1'b0;
      end
   end

   // Next grant: winner search (released owner excluded) and FSM transitions.
   always_comb begin
      state_n     = state_r;
      gnt_n       = gnt_r;
      owner_n     = owner_r;
      rr_ptr_n    = rr_ptr_r;
      new_grant_s = 1'b0;
      if (state_r == IDLE) begin
         cand_s = req;
      end else if (release_s) begin
         cand_s = req & ~owner_mask_s;
      end else begin
         cand_s = {NUM_REQ{1'b0}};
      end
      pick_s      = pick_winner(cand_s, rr_ptr_r);
      win_found_s = pick_s[IDX_W];
      win_idx_s   = pick_s[IDX_W-1:0];
      case (state_r)
         IDLE, OWNED: begin
            if (win_found_s) begin
               state_n     = OWNED;
               owner_n     = win_idx_s;
               gnt_n       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
               new_grant_s = 1'b1;
               if (win_idx_s == IDX_W'(NUM_REQ - 1)) begin
                  rr_ptr_n = {IDX_W{1'b0}};
               end else begin
                  rr_ptr_n = win_idx_s + IDX_W'(1);
               end
            end else if (release_s) begin
               state_n = IDLE;
               gnt_n   = {NUM_REQ{1'b0}};
            end else begin
               state_n = state_r;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = {NUM_REQ{1'b0}};
         end
      endcase
   end

   // Read data valid is flagged for the requester one cycle after its read access.
   always_comb begin
      if (access_s && !we[owner_r]) begin
         rvalid_n = owner_mask_s;
      end else begin
         rvalid_n = {NUM_REQ{1'b0}};
      end
   end

   // Arbiter state, grant, pointer and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         gnt_r     <= {NUM_REQ{1'b0}};
         owner_r   <= {IDX_W{1'b0}};
         rr_ptr_r  <= {IDX_W{1'b0}};
         rvalid_r  <= {NUM_REQ{1'b0}};
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_n;
         gnt_r     <= gnt_n;
         owner_r   <= owner_n;
         rr_ptr_r  <= rr_ptr_n;
         rvalid_r  <= rvalid_n;
         timeout_r <= force_s;
      end
   end

   // RAM control mux from the registered owner; everything idle outside an access cycle.
   always_comb begin
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_oe    = 1'b0;
      ram_addr  = {ADDR_W{1'b0}};
      ram_wdata = {DATA_W{1'b0}};
      if (access_s) begin
         ram_cs    = 1'b1;
         ram_we    = we[owner_r];
         ram_oe    = ~we[owner_r];
         ram_addr  = addr[int'(owner_r)*ADDR_W +: ADDR_W];
         ram_wdata = wdata[int'(owner_r)*DATA_W +: DATA_W];
      end else begin
         ram_cs    = 1'b0;
      end
   end

   assign gnt     = gnt_r;
   assign rvalid  = rvalid_r;
   assign rdata   = ram_rdata;
   assign busy    = (state_r == OWNED);
   assign timeout = timeout_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural single-port RAM.
module tb_ram_port_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD = 4;
`else
   localparam int HOLD = 255;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req = 3'b000, lock = 3'b000, we = 3'b000;
   logic [23:0] addr = 24'h0, wdata = 24'h0;
   logic [2:0]  gnt, rvalid;
   logic [7:0]  rdata, ram_addr, ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;
   logic        ram_cs, ram_we, ram_oe, busy, timeout;
   logic [7:0]  mem [0:255];

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8), .MAX_HOLD(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_cs(ram_cs),
      .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy), .timeout(timeout)
   );

   // Single-port RAM: synchronous write, read data one cycle after the read cycle.
   always @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_cs && ram_oe) ram_rdata <= mem[ram_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] exp_gnt [0:5];
   int rv1_cnt;
   int bad_rd;

   initial begin
      exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100;
      exp_gnt[3] = 3'b001; exp_gnt[4] = 3'b010; exp_gnt[5] = 3'b100;

      // Reset state
      #2;
      check_eq("rst_gnt", gnt, 3'b000);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_cs", ram_cs, 1'b0);
      check_eq("rst_rvalid", rvalid, 3'b000);
      check_eq("rst_timeout", timeout, 1'b0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Single write by requester 0
      req = 3'b001; we = 3'b001; addr = 24'h000010; wdata = 24'h0000A5;
      step(); @(negedge clk);
      check_eq("wr_gnt", gnt, 3'b001);
      check_eq("wr_busy", busy, 1'b1);
      check_eq("wr_ctl", {ram_cs, ram_we, ram_oe}, 3'b110);
      check_eq("wr_addr", ram_addr, 8'h10);
      check_eq("wr_data", ram_wdata, 8'hA5);
      step(); req = 3'b000; we = 3'b000;
      @(negedge clk);
      check_eq("wr_release", gnt, 3'b000);
      check_eq("wr_idle", busy, 1'b0);
      check_eq("wr_mem", mem[16], 8'hA5);

      // Read latency, requester 1
      req = 3'b010; we = 3'b000; addr = 24'h001000;
      step(); @(negedge clk);
      check_eq("rd_gnt", gnt, 3'b010);
      check_eq("rd_ctl", {ram_cs, ram_we, ram_oe}, 3'b101);
      check_eq("rd_rvalid_early", rvalid, 3'b000);
      step(); req = 3'b000;
      @(negedge clk);
      check_eq("rd_rvalid", rvalid, 3'b010);
      check_eq("rd_rdata", rdata, 8'hA5);
      check_eq("rd_release", gnt, 3'b000);
      step(); @(negedge clk);
      check_eq("rd_rvalid_clr", rvalid, 3'b000);

      // Reset to restart the pointer, then round-robin with all requesting
      rst_n = 1'b0; #1;
      check_eq("rst2_gnt", gnt, 3'b000);
      step(); rst_n = 1'b1;
      req = 3'b111; we = 3'b111; lock = 3'b000;
      addr = 24'h222120; wdata = 24'h323130;
      for (int c = 0; c < 6; c++) begin
         step(); @(negedge clk);
         check_eq("rr_gnt", gnt, exp_gnt[c]);
         check_eq("rr_addr", ram_addr, 8'h20 + 8'(c % 3));
         check_eq("rr_cs", ram_cs, 1'b1);
      end
      step(); req = 3'b000; we = 3'b000;
      @(negedge clk);
      check_eq("rr_wrap", gnt, 3'b001);
      step(); @(negedge clk);
      check_eq("rr_idle", gnt, 3'b000);
      check_eq("rr_mem", mem[8'h22], 8'h32);

      // Burst lock: requester 1 locked for 10 reads while requester 2 waits
      req = 3'b110; lock = 3'b010; we = 3'b000; addr = 24'h501000;
      rv1_cnt = 0; bad_rd = 0;
      for (int c = 1; c <= 13; c++) begin
         step();
         if (c == 10) lock = 3'b000;
         if (c == 11) req = 3'b100;
         if (c == 12) req = 3'b000;
         @(negedge clk);
         if (c <= 10) check_eq("burst_hold", gnt, 3'b010);
         if (c == 11) check_eq("burst_handover", gnt, 3'b100);
         if (c == 12) check_eq("burst_rv2", rvalid, 3'b100);
         if (rvalid[1]) begin
            rv1_cnt++;
            if (rdata !== 8'hA5) bad_rd++;
         end
      end
      check_eq("burst_rv1_cnt", rv1_cnt, 10);
      check_eq("burst_rdata", bad_rd, 0);

      // Asynchronous reset in the middle of a locked burst
      req = 3'b001; lock = 3'b001; we = 3'b000; addr = 24'h000010;
      step(); @(negedge clk);
      check_eq("mid_gnt", gnt, 3'b001);
      step(); @(negedge clk);
      check_eq("mid_rvalid", rvalid, 3'b001);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_gnt", gnt, 3'b000);
      check_eq("mid_rst_cs", ram_cs, 1'b0);
      check_eq("mid_rst_rvalid", rvalid, 3'b000);
      check_eq("mid_rst_busy", busy, 1'b0);
      req = 3'b000; lock = 3'b000;
      step(); step(); rst_n = 1'b1;
      step();

      // Long lock by requester 2 with requester 0 waiting
      req = 3'b100; lock = 3'b100; we = 3'b101; addr = 24'h600061; wdata = 24'h770011;
      step(); req = 3'b101;
      @(negedge clk);
      check_eq("to_gnt", gnt, 3'b100);
      for (int c = 2; c <= 4; c++) begin
         step(); @(negedge clk);
         check_eq("to_hold", gnt, 3'b100);
         check_eq("to_quiet", timeout, 1'b0);
      end
      step(); @(negedge clk);
`ifdef ARB_TIMEOUT_EN
      check_eq("to_forced_gnt", gnt, 3'b001);
      check_eq("to_pulse", timeout, 1'b1);
`else
      check_eq("to_forced_gnt", gnt, 3'b100);
      check_eq("to_pulse", timeout, 1'b0);
`endif
      step(); @(negedge clk);
      check_eq("to_regrant", gnt, 3'b100);
      check_eq("to_pulse_end", timeout, 1'b0);
      step(); req = 3'b000; lock = 3'b000; we = 3'b000;
      step(); @(negedge clk);
      check_eq("to_idle", gnt, 3'b000);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
